// File: rtl/scr1_axi_arb_pkg.sv
// Shared types and constants for the SCR1 AXI read-channel arbiter.
package scr1_axi_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_e;

  localparam logic ARB_OWN_IMEM = 1'b0;
  localparam logic ARB_OWN_DMEM = 1'b1;

  // Merged ID width: the wider of the two master IDs plus one owner bit on top.
  function automatic int arb_m_id_w(input int imem_id_w, input int dmem_id_w);
    return ((imem_id_w > dmem_id_w) ? imem_id_w : dmem_id_w) + 1;
  endfunction

endpackage

// File: rtl/scr1_axi_rd_arb.sv
// Two-to-one AXI4 read arbiter between SCR1 IMEM fetch (port 0) and DMEM load
// (port 1). One transaction in flight, round-robin on ties, R beats routed back
// to the owner, sticky checks of RLAST position and RID against the issued AR.
//
// state    | meaning
// ARB_IDLE | arbitrate; arready goes combinationally to the winner only
// ARB_ADDR | registered request held on m_ar* until m_arready
// ARB_DATA | R beats passed through to the owner until the RLAST handshake
module scr1_axi_rd_arb
  import scr1_axi_arb_pkg::*;
#(
  parameter int IMEM_ID_W = 3,
  parameter int DMEM_ID_W = 2,
  parameter int M_ID_W    = arb_m_id_w(IMEM_ID_W, DMEM_ID_W)
) (
  input  logic                 clk_riscv,
  input  logic                 rstn_riscv,

  input  logic [IMEM_ID_W-1:0] s0_arid,
  input  logic [31:0]          s0_araddr,
  input  logic [7:0]           s0_arlen,
  input  logic [2:0]           s0_arsize,
  input  logic [1:0]           s0_arburst,
  input  logic                 s0_arvalid,
  output logic                 s0_arready,
  output logic [IMEM_ID_W-1:0] s0_rid,
  output logic [31:0]          s0_rdata,
  output logic [1:0]           s0_rresp,
  output logic                 s0_rlast,
  output logic                 s0_rvalid,
  input  logic                 s0_rready,

  input  logic [DMEM_ID_W-1:0] s1_arid,
  input  logic [31:0]          s1_araddr,
  input  logic [7:0]           s1_arlen,
  input  logic [2:0]           s1_arsize,
  input  logic [1:0]           s1_arburst,
  input  logic                 s1_arvalid,
  output logic                 s1_arready,
  output logic [DMEM_ID_W-1:0] s1_rid,
  output logic [31:0]          s1_rdata,
  output logic [1:0]           s1_rresp,
  output logic                 s1_rlast,
  output logic                 s1_rvalid,
  input  logic                 s1_rready,

  output logic [M_ID_W-1:0]    m_arid,
  output logic [31:0]          m_araddr,
  output logic [7:0]           m_arlen,
  output logic [2:0]           m_arsize,
  output logic [1:0]           m_arburst,
  output logic                 m_arvalid,
  input  logic                 m_arready,
  input  logic [M_ID_W-1:0]    m_rid,
  input  logic [31:0]          m_rdata,
  input  logic [1:0]           m_rresp,
  input  logic                 m_rlast,
  input  logic                 m_rvalid,
  output logic                 m_rready,

  output logic                 err_len,
  output logic                 err_id
);

  arb_state_e          state;
  logic                rr_last;
  logic                win;
  logic                win_vld;
  logic [M_ID_W-2:0]   id_ext;
  logic [8:0]          beat_cnt;
  logic                own;
  logic                in_data;
  logic                r_hs;

  // The owner is the top bit of the issued ID; it is only meaningful in ADDR/DATA.
  assign own     = m_arid[M_ID_W-1];
  assign in_data = (state == ARB_DATA);

  // Round-robin pick among the current IDLE requesters; no grant is latched.
  always_comb begin
    win     = ARB_OWN_IMEM;
    win_vld = 1'b0;
    if (state == ARB_IDLE) begin
      if (s0_arvalid && s1_arvalid) begin
        win     = ~rr_last;
        win_vld = 1'b1;
      end else if (s0_arvalid) begin
        win     = ARB_OWN_IMEM;
        win_vld = 1'b1;
      end else if (s1_arvalid) begin
        win     = ARB_OWN_DMEM;
        win_vld = 1'b1;
      end
    end
  end

  assign s0_arready = win_vld && (win == ARB_OWN_IMEM);
  assign s1_arready = win_vld && (win == ARB_OWN_DMEM);

  // Zero-extend the winner's ID to the width below the owner bit.
  always_comb begin
    id_ext = '0;
    if (win == ARB_OWN_DMEM) begin
      id_ext[DMEM_ID_W-1:0] = s1_arid;
    end else begin
      id_ext[IMEM_ID_W-1:0] = s0_arid;
    end
  end

  // R channel is a zero-latency passthrough gated to the owner during DATA.
  assign m_rready  = in_data && (own ? s1_rready : s0_rready);
  assign r_hs      = m_rvalid && m_rready;

  assign s0_rvalid = in_data && (own == ARB_OWN_IMEM) && m_rvalid;
  assign s0_rid    = m_arid[IMEM_ID_W-1:0];
  assign s0_rdata  = m_rdata;
  assign s0_rresp  = m_rresp;
  assign s0_rlast  = m_rlast;

  assign s1_rvalid = in_data && (own == ARB_OWN_DMEM) && m_rvalid;
  assign s1_rid    = m_arid[DMEM_ID_W-1:0];
  assign s1_rdata  = m_rdata;
  assign s1_rresp  = m_rresp;
  assign s1_rlast  = m_rlast;

  // Transaction FSM with registered AR outputs, beat counter and sticky error flags.
  always_ff @(posedge clk_riscv or negedge rstn_riscv) begin
    if (!rstn_riscv) begin
      state     <= ARB_IDLE;
      rr_last   <= ARB_OWN_DMEM;
      m_arvalid <= 1'b0;
      m_arid    <= '0;
      m_araddr  <= '0;
      m_arlen   <= '0;
      m_arsize  <= '0;
      m_arburst <= '0;
      beat_cnt  <= '0;
      err_len   <= 1'b0;
      err_id    <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (win_vld) begin
            state     <= ARB_ADDR;
            rr_last   <= win;
            m_arvalid <= 1'b1;
            m_arid    <= {win, id_ext};
            if (win == ARB_OWN_DMEM) begin
              m_araddr  <= s1_araddr;
              m_arlen   <= s1_arlen;
              m_arsize  <= s1_arsize;
              m_arburst <= s1_arburst;
            end else begin
              m_araddr  <= s0_araddr;
              m_arlen   <= s0_arlen;
              m_arsize  <= s0_arsize;
              m_arburst <= s0_arburst;
            end
          end
        end
        ARB_ADDR: begin
          if (m_arready) begin
            state     <= ARB_DATA;
            m_arvalid <= 1'b0;
            beat_cnt  <= '0;
          end
        end
        ARB_DATA: begin
          if (r_hs) begin
            beat_cnt <= beat_cnt + 9'd1;
            // RLAST must appear exactly on beat number arlen; the burst still
            // ends on RLAST alone so a misbehaving slave cannot hang the port.
            if (m_rlast != (beat_cnt == {1'b0, m_arlen})) begin
              err_len <= 1'b1;
            end
            if (m_rid != m_arid) begin
              err_id <= 1'b1;
            end
            if (m_rlast) begin
              state <= ARB_IDLE;
            end
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule
